// File: rtl/snn_fp_pkg.sv
// Shared FP32 constants and the adder sequencing states for the neuron datapath.
package snn_fp_pkg;

  localparam int          EXP_W    = 8;
  localparam int          MAN_W    = 23;
  localparam logic [7:0]  EXP_BIAS = 8'd127;
  localparam logic [7:0]  EXP_MAX  = 8'd255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [2:0] {
    LOAD,
    ALIGN,
    ADD,
    NORM,
    ROUND
  } add_state_e;

  // Leading-zero count of a 27-bit significand; 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_ge.sv
// Combinational ordered FP32 a >= b; any NaN compares false and +0 equals -0.
module fp32_ge (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ge_o
);

  logic a_nan, b_nan, both_zero;

  always_comb begin
    a_nan     = (&a_i[30:23]) && (|a_i[22:0]);
    b_nan     = (&b_i[30:23]) && (|b_i[22:0]);
    both_zero = (a_i[30:0] == 31'd0) && (b_i[30:0] == 31'd0);
    ge_o      = 1'b0;
    if (a_nan || b_nan)        ge_o = 1'b0;
    else if (both_zero)        ge_o = 1'b1;
    else if (a_i[31] != b_i[31]) ge_o = b_i[31];
    else if (!a_i[31])         ge_o = (a_i[30:0] >= b_i[30:0]);
    else                       ge_o = (a_i[30:0] <= b_i[30:0]);
  end

endmodule

// File: rtl/potential_adder.sv
// Free-running five-state FP32 adder: decayed potential + synaptic weight,
// with a registered spike flag against the firing threshold.
module potential_adder
  import snn_fp_pkg::*;
#(
  parameter logic [31:0] V_THRESHOLD = 32'h42200000
) (
  input  logic        CLK_Adder,
  input  logic        clear,
  input  logic [31:0] input_weight,
  input  logic [31:0] decayed_potential,
  output logic [31:0] final_potential,
  output logic        spike,
  output logic        adderoutput9,
  output logic        adderoutput8,
  output logic        adderoutput7,
  output logic        adderoutput6,
  output logic        adderoutput5,
  output logic        adderoutput4,
  output logic        adderoutput3,
  output logic        adderoutput2,
  output logic        adderoutput1,
  output logic        adderoutput0,
  output logic        done
);

  add_state_e state_q, state_d;
  logic ld_en, al_en, add_en, nrm_en, rnd_en;

  logic [31:0]       op_a_q, op_b_q;
  logic              sign_q, sub_q, nan_q, inf_q, inf_sign_q;
  logic signed [9:0] exp_a_q;
  logic [26:0]       sig_a_q, sig_b_q;
  logic [27:0]       sum_q;
  logic [26:0]       norm_q;
  logic signed [9:0] exp_n_q;
  logic              zero_q, uflow_q;
  logic [31:0]       final_q;
  logic              spike_q, done_q;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK_Adder) begin
    if (clear) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = LOAD;
    unique case (state_q)
      LOAD:    state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    ld_en  = (state_q == LOAD);
    al_en  = (state_q == ALIGN);
    add_en = (state_q == ADD);
    nrm_en = (state_q == NORM);
    rnd_en = (state_q == ROUND);
  end

  // ---------------- ALIGN: unpack, swap, shift ----------------
  logic [30:0] mag_a, mag_b, mag_big, mag_small;
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic        sign_big, sign_small;
  logic [23:0] sig_big, sig_small;
  logic [7:0]  diff;
  logic [53:0] wide;
  logic [26:0] sig_small_al;

  always_comb begin
    a_nan = (op_a_q[30:23] == EXP_MAX) && (op_a_q[MAN_W-1:0] != '0);
    b_nan = (op_b_q[30:23] == EXP_MAX) && (op_b_q[MAN_W-1:0] != '0);
    a_inf = (op_a_q[30:23] == EXP_MAX) && (op_a_q[MAN_W-1:0] == '0);
    b_inf = (op_b_q[30:23] == EXP_MAX) && (op_b_q[MAN_W-1:0] == '0);
    // Subnormals flush to zero before the magnitude compare.
    mag_a = (op_a_q[30:23] == '0) ? 31'd0 : op_a_q[30:0];
    mag_b = (op_b_q[30:23] == '0) ? 31'd0 : op_b_q[30:0];
    swap       = (mag_b > mag_a);
    mag_big    = swap ? mag_b : mag_a;
    mag_small  = swap ? mag_a : mag_b;
    sign_big   = swap ? op_b_q[31] : op_a_q[31];
    sign_small = swap ? op_a_q[31] : op_b_q[31];
    sig_big    = (mag_big[30:23] == '0)   ? 24'd0 : {1'b1, mag_big[MAN_W-1:0]};
    sig_small  = (mag_small[30:23] == '0) ? 24'd0 : {1'b1, mag_small[MAN_W-1:0]};
    diff       = mag_big[30:23] - mag_small[30:23];
    wide       = {sig_small, 3'b000, 27'd0} >> diff;
    if (diff >= 8'd27) sig_small_al = {26'd0, |sig_small};
    else               sig_small_al = {wide[53:28], wide[27] | (|wide[26:0])};
  end

  // ---------------- ADD ----------------
  logic [27:0] sum_d;

  always_comb begin
    if (sub_q) sum_d = {1'b0, sig_a_q} - {1'b0, sig_b_q};
    else       sum_d = {1'b0, sig_a_q} + {1'b0, sig_b_q};
  end

  // ---------------- NORM ----------------
  logic [4:0]        lz;
  logic [26:0]       norm_d;
  logic signed [9:0] exp_n_d;

  always_comb begin
    lz = lzc27(sum_q[26:0]);
    if (sum_q[27]) begin
      norm_d  = {sum_q[27:2], |sum_q[1:0]};
      exp_n_d = exp_a_q + 10'sd1;
    end else begin
      norm_d  = sum_q[26:0] << lz;
      exp_n_d = exp_a_q - $signed({5'd0, lz});
    end
  end

  // ---------------- ROUND and pack ----------------
  logic              rnd_up;
  logic [24:0]       mant_r;
  logic [23:0]       sig_r;
  logic signed [9:0] exp_r;
  logic [31:0]       result_d;
  logic              ge_thr;

  always_comb begin
    rnd_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    mant_r = {1'b0, norm_q[26:3]} + {24'd0, rnd_up};
    if (mant_r[24]) begin
      sig_r = mant_r[24:1];
      exp_r = exp_n_q + 10'sd1;
    end else begin
      sig_r = mant_r[23:0];
      exp_r = exp_n_q;
    end
    if (nan_q)                             result_d = QNAN;
    else if (inf_q)                        result_d = {inf_sign_q, EXP_MAX, 23'd0};
    else if (zero_q)                       result_d = 32'd0;
    else if (uflow_q)                      result_d = {sign_q, 31'd0};
    else if (exp_r >= $signed({2'b00, EXP_MAX})) result_d = {sign_q, EXP_MAX, 23'd0};
    else                                   result_d = {sign_q, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
  end

  fp32_ge u_spike_cmp (
    .a_i  (result_d),
    .b_i  (V_THRESHOLD),
    .ge_o (ge_thr)
  );

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK_Adder) begin
    if (clear) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      inf_sign_q <= 1'b0;
      exp_a_q    <= '0;
      sig_a_q    <= '0;
      sig_b_q    <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      exp_n_q    <= '0;
      zero_q     <= 1'b0;
      uflow_q    <= 1'b0;
      final_q    <= '0;
      spike_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= rnd_en;
      if (ld_en) begin
        op_a_q <= input_weight;
        op_b_q <= decayed_potential;
      end
      if (al_en) begin
        sign_q     <= sign_big;
        sub_q      <= sign_big ^ sign_small;
        nan_q      <= a_nan | b_nan | (a_inf & b_inf & (op_a_q[31] ^ op_b_q[31]));
        inf_q      <= a_inf | b_inf;
        inf_sign_q <= a_inf ? op_a_q[31] : op_b_q[31];
        exp_a_q    <= $signed({2'b00, mag_big[30:23]});
        sig_a_q    <= {sig_big, 3'b000};
        sig_b_q    <= sig_small_al;
      end
      if (add_en) sum_q <= sum_d;
      if (nrm_en) begin
        norm_q  <= norm_d;
        exp_n_q <= exp_n_d;
        zero_q  <= (sum_q == 28'd0);
        uflow_q <= (exp_n_d <= 10'sd0);
      end
      if (rnd_en) begin
        final_q <= result_d;
        spike_q <= ge_thr;
      end
    end
  end

  assign final_potential = final_q;
  assign spike           = spike_q;
  assign done            = done_q;
  assign {adderoutput9, adderoutput8, adderoutput7, adderoutput6, adderoutput5,
          adderoutput4, adderoutput3, adderoutput2, adderoutput1, adderoutput0} = final_q[31:22];

endmodule

// File: tb/tb_potential_adder.sv
// Scoreboard bench for potential_adder: directed FP32 vectors with hand-computed sums.
module tb_potential_adder;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] w, p;
  logic [31:0] final_potential;
  logic        spike, done;
  logic        ao9, ao8, ao7, ao6, ao5, ao4, ao3, ao2, ao1, ao0;

  always #5 clk = ~clk;

  potential_adder #(.V_THRESHOLD(32'h42200000)) dut (
    .CLK_Adder         (clk),
    .clear             (clear),
    .input_weight      (w),
    .decayed_potential (p),
    .final_potential   (final_potential),
    .spike             (spike),
    .adderoutput9      (ao9),
    .adderoutput8      (ao8),
    .adderoutput7      (ao7),
    .adderoutput6      (ao6),
    .adderoutput5      (ao5),
    .adderoutput4      (ao4),
    .adderoutput3      (ao3),
    .adderoutput2      (ao2),
    .adderoutput1      (ao1),
    .adderoutput0      (ao0),
    .done              (done)
  );

  typedef struct {
    logic [31:0] res;
    logic        spk;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  function automatic logic [9:0] dbg();
    return {ao9, ao8, ao7, ao6, ao5, ao4, ao3, ao2, ao1, ao0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check("final_potential", final_potential, e.res);
          check("spike", {31'd0, spike}, {31'd0, e.spk});
          check("adderoutput", {22'd0, dbg()}, {22'd0, e.res[31:22]});
          check("done_latency", cyc, e.cyc + 5);
        end
      end
    end
  end

  // Called on a negedge while the DUT sits in LOAD; returns on the negedge of the done cycle.
  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic spk, input bit disturb);
    exp_t e;
    w = a;
    p = b;
    e.res = res;
    e.spk = spk;
    e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (disturb) begin
      w = $urandom;
      p = $urandom;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    w = 32'h3F800000;
    p = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_final", final_potential, 32'd0);
      check("reset_spike", {31'd0, spike}, 32'd0);
      check("reset_dbg", {22'd0, dbg()}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
    end
    clear = 1'b0;

    apply(32'h42470A3D, 32'h425ED852, 32'h42D2F148, 1'b1, 1'b1);
    apply(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    apply(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    apply(32'h40A00000, 32'hC0A00000, 32'h00000000, 1'b0, 1'b1);
    apply(32'h41A00000, 32'h41A00000, 32'h42200000, 1'b1, 1'b1);
    apply(32'h42400000, 32'hC1C00000, 32'h41C00000, 1'b0, 1'b1);

    // Abort during ADD: no done, outputs cleared, restart from LOAD.
    w = 32'h41A00000;
    p = 32'h41A00000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_final", final_potential, 32'd0);
    check("abort_spike", {31'd0, spike}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    clear = 1'b0;

    apply(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1);
    apply(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
    apply(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b1);
    apply(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b1);
    apply(32'hC2480000, 32'h00000000, 32'hC2480000, 1'b0, 1'b1);
    apply(32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    apply(32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b1);
    apply(32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0, 1'b1);
    apply(32'h3F800000, 32'hBF000000, 32'h3F000000, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
